cnn_layer_ctrl: RTL
===================

CNN_LAYER_CTRL -- requirements
Module: cnn_layer_ctrl

Interface
REQ-001 Parameters SHALL be: W_SIZE 10 (row/col width); W_CHANNEL 8 (channel-tile count width); W_DELAY 12 (sync counter width); IFM_ROWS 4 (IFM row-buffer depth in rows, >=3).
REQ-002 clk  in  1  clock; rstn  in  1  reset, asynchronous, active-low.
REQ-003 q_start  in  1  one-cycle pulse; latches all q_* configuration fields.
REQ-004 q_abort  in  1  terminates the layer.
REQ-005 q_kernel3  in  1  selects kernel size: 0 = 1x1, 1 = 3x3.
REQ-006 q_width, q_height  in  W_SIZE  tile frame dimensions.
REQ-007 q_in_chn, q_out_chn  in  W_CHANNEL  input and output channel-tile counts.
REQ-008 q_filter_done, q_ifm_done  in  1  buffer-manager completion pulses.
REQ-009 q_pe_ready  in  1  PE accepts a beat this cycle.
REQ-010 o_filter_req  out  1  one-cycle pulse requesting the filter tile o_ochn.
REQ-011 o_ifm_req_load  out  1  one-cycle pulse; o_ifm_req_row  out  W_SIZE  row to load.
REQ-012 o_hsync_run, o_data_run, o_busy  out  1  state indicators; o_hsync_cnt  out  W_DELAY  cycles spent in HSYNC.
REQ-013 o_row, o_col  out  W_SIZE; o_chn, o_ochn  out  W_CHANNEL  current beat position.
REQ-014 o_flags  out  6  {first_row, last_row, first_col, last_col, first_chn, last_chn}.
REQ-015 o_beat  out  1  (o_data_run & q_pe_ready); o_done  out  1  one-cycle pulse on the final beat or on abort.

Function
REQ-016 FSM states SHALL be IDLE, FILT, HSYNC, DATA; o_busy is high in every state except IDLE.
REQ-017 IDLE->FILT on q_start with every dimension nonzero; q_start with any dimension zero SHALL pulse o_done next cycle, issue no requests and remain in IDLE.
REQ-018 On entry to FILT the block SHALL pulse o_filter_req once; FILT->HSYNC on q_filter_done.
REQ-019 Loop order SHALL be col fastest, then chn, then row, then ochn; counters advance only on o_beat.
REQ-020 HSYNC->DATA when rows up to min(row+P, height-1) are loaded, where P = 1 for 3x3 and P = 0 for 1x1.
REQ-021 DATA->HSYNC on a beat with last_col & last_chn & !last_row.
REQ-022 DATA->FILT on a beat with last_col & last_chn & last_row & ochn != q_out_chn-1; this clears row, col and chn, increments ochn, and resets the loaded-row count to 0.
REQ-023 The final beat (all last, ochn = q_out_chn-1) SHALL pulse o_done, go to IDLE and clear all position counters.
REQ-024 IFM loads SHALL be sequential from row 0 with at most one outstanding load, issued only in HSYNC or DATA, and each q_ifm_done SHALL increment the loaded-row count.
REQ-025 Row r SHALL not be requested while r - max(row-P, 0) >= IFM_ROWS (buffer full); the request is issued the cycle after space frees.
REQ-026 No load SHALL be requested past height-1; q_ifm_done with no load outstanding SHALL be ignored.
REQ-027 q_abort in any non-IDLE state SHALL go to IDLE next cycle, pulse o_done, clear counters and outstanding flags; a late q_ifm_done/q_filter_done is ignored.
REQ-028 q_start while busy SHALL be ignored; q_abort and q_start in the same cycle in IDLE: abort wins, no start.
REQ-029 o_hsync_cnt SHALL increment each HSYNC cycle, saturate at all-ones and clear outside HSYNC.
REQ-030 Flags SHALL be combinational from the counters and the latched configuration.

Reset
REQ-031 With rstn low, state SHALL be IDLE, all counters and latched configuration 0, and every output 0.
REQ-032 Reset deassertion SHALL take effect synchronously to clk; no request is issued in the first cycle after reset.

Structure
REQ-033 The state encoding, flag bit indices and parameter defaults SHALL live in the shared controller params package/header.
REQ-034 IFM row prefetch (REQ-024..026) SHALL be a sub-module ifm_row_prefetch; FSM and counters remain in cnn_layer_ctrl.

Verification
REQ-035 3x3, 4x3, in 2, out 1, pe_ready=1, instant dones -> 24 beats, o_done on beat 24, 3 loads rows 0..2.
REQ-036 Same config, out 2 -> 2 filter requests, rows 0..2 loaded twice, 48 beats, o_ochn=1 on beats 25..48.
REQ-037 1x1, height 8, IFM_ROWS 4, q_ifm_done delayed 5 cycles -> first DATA after row 0 is loaded, never more than 4 rows ahead of the current row.
REQ-038 q_pe_ready toggled 1/0 -> counters move only on o_beat, beat count unchanged, o_done once.
REQ-039 q_abort mid-DATA with a load outstanding -> IDLE next cycle, o_done pulse, the later q_ifm_done causes no change, restart behaves as after reset.
REQ-040 q_start with q_width=0 -> o_done next cycle, no requests.

Source files
------------

// File: rtl/cnn_layer_ctrl_pkg.sv
// Shared controller parameters: defaults, FSM encoding
// and flag bit positions for the CNN layer controller.
package cnn_layer_ctrl_pkg;

    localparam int DEF_W_SIZE    = 10;
    localparam int DEF_W_CHANNEL = 8;
    localparam int DEF_W_DELAY   = 12;
    localparam int DEF_IFM_ROWS  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILT  = 2'd1;
    localparam logic [1:0] ST_HSYNC = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    localparam int N_FLAGS       = 6;
    localparam int FLG_FIRST_ROW = 5;
    localparam int FLG_LAST_ROW  = 4;
    localparam int FLG_FIRST_COL = 3;
    localparam int FLG_LAST_COL  = 2;
    localparam int FLG_FIRST_CHN = 1;
    localparam int FLG_LAST_CHN  = 0;

endpackage

// File: rtl/cnn_layer_ctrl_if.sv
// Command/status bundle between the layer sequencer
// and the CNN layer controller.
interface cnn_layer_ctrl_if
    import cnn_layer_ctrl_pkg::*;
#(
    parameter int W_SIZE    = DEF_W_SIZE,
    parameter int W_CHANNEL = DEF_W_CHANNEL,
    parameter int W_DELAY   = DEF_W_DELAY
) ();

    logic                 q_start;
    logic                 q_abort;
    logic                 q_kernel3;
    logic [W_SIZE-1:0]    q_width;
    logic [W_SIZE-1:0]    q_height;
    logic [W_CHANNEL-1:0] q_in_chn;
    logic [W_CHANNEL-1:0] q_out_chn;
    logic                 q_filter_done;
    logic                 q_ifm_done;
    logic                 q_pe_ready;

    logic                 o_filter_req;
    logic                 o_ifm_req_load;
    logic [W_SIZE-1:0]    o_ifm_req_row;
    logic                 o_hsync_run;
    logic                 o_data_run;
    logic                 o_busy;
    logic [W_DELAY-1:0]   o_hsync_cnt;
    logic [W_SIZE-1:0]    o_row;
    logic [W_SIZE-1:0]    o_col;
    logic [W_CHANNEL-1:0] o_chn;
    logic [W_CHANNEL-1:0] o_ochn;
    logic [N_FLAGS-1:0]   o_flags;
    logic                 o_beat;
    logic                 o_done;

    modport master (
        output q_start, q_abort, q_kernel3,
        output q_width, q_height,
        output q_in_chn, q_out_chn,
        output q_filter_done, q_ifm_done,
        output q_pe_ready,
        input  o_filter_req, o_ifm_req_load,
        input  o_ifm_req_row, o_hsync_run,
        input  o_data_run, o_busy, o_hsync_cnt,
        input  o_row, o_col, o_chn, o_ochn,
        input  o_flags, o_beat, o_done
    );

    modport slave (
        input  q_start, q_abort, q_kernel3,
        input  q_width, q_height,
        input  q_in_chn, q_out_chn,
        input  q_filter_done, q_ifm_done,
        input  q_pe_ready,
        output o_filter_req, o_ifm_req_load,
        output o_ifm_req_row, o_hsync_run,
        output o_data_run, o_busy, o_hsync_cnt,
        output o_row, o_col, o_chn, o_ochn,
        output o_flags, o_beat, o_done
    );

endinterface

// File: rtl/cnn_layer_ctrl_ifm_row_prefetch.sv
// Sequential IFM row loader: one load in flight, bounded
// by the row-buffer depth behind the oldest row in use.
module ifm_row_prefetch
    import cnn_layer_ctrl_pkg::*;
#(
    parameter int W_SIZE   = DEF_W_SIZE,
    parameter int IFM_ROWS = DEF_IFM_ROWS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              active,
    input  logic              k3,
    input  logic [W_SIZE-1:0] height,
    input  logic [W_SIZE-1:0] row,
    input  logic              ifm_done,
    output logic              req_load,
    output logic [W_SIZE-1:0] req_row,
    output logic              ready
);

    localparam logic [W_SIZE:0] ONE = 1;
    localparam logic [W_SIZE:0] LIM = (W_SIZE+1)'(IFM_ROWS);

    logic [W_SIZE:0] loaded;
    logic [W_SIZE:0] row_x;
    logic [W_SIZE:0] hgt_x;
    logic [W_SIZE:0] base;
    logic [W_SIZE:0] need;
    logic            pend;
    logic            room;
    logic            issue;

    assign row_x = {1'b0, row};
    assign hgt_x = {1'b0, height};

    // 3x3 keeps row-1 resident and needs row+1 before computing
    assign base = (k3 && row != '0) ? row_x - ONE : row_x;
    assign need = (k3 && row_x != hgt_x - ONE) ? row_x + ONE : row_x;

    assign ready = loaded > need;
    assign room  = (loaded < base) || ((loaded - base) < LIM);
    assign issue = active && !clear && !pend
                && (loaded < hgt_x) && room;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loaded   <= '0;
            pend     <= 1'b0;
            req_load <= 1'b0;
            req_row  <= '0;
        end else if (clear) begin
            loaded   <= '0;
            pend     <= 1'b0;
            req_load <= 1'b0;
            req_row  <= '0;
        end else begin
            req_load <= issue;
            if (issue) begin
                req_row <= loaded[W_SIZE-1:0];
                pend    <= 1'b1;
            end else if (ifm_done && pend) begin
                pend   <= 1'b0;
                loaded <= loaded + ONE;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_ctrl.sv
// Layer sequencer: filter fetch, row sync and beat
// counters over col, chn, row, ochn.
module cnn_layer_ctrl
    import cnn_layer_ctrl_pkg::*;
#(
    parameter int W_SIZE    = DEF_W_SIZE,
    parameter int W_CHANNEL = DEF_W_CHANNEL,
    parameter int W_DELAY   = DEF_W_DELAY,
    parameter int IFM_ROWS  = DEF_IFM_ROWS
) (
    input logic             clk,
    input logic             rstn,
    cnn_layer_ctrl_if.slave bus
);

    localparam logic [W_SIZE-1:0]    ONE_S = 1;
    localparam logic [W_CHANNEL-1:0] ONE_C = 1;
    localparam logic [W_DELAY-1:0]   ONE_D = 1;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 k3;
    logic [W_SIZE-1:0]    cfg_w;
    logic [W_SIZE-1:0]    cfg_h;
    logic [W_CHANNEL-1:0] cfg_ic;
    logic [W_CHANNEL-1:0] cfg_oc;
    logic [W_SIZE-1:0]    row;
    logic [W_SIZE-1:0]    col;
    logic [W_CHANNEL-1:0] chn;
    logic [W_CHANNEL-1:0] ochn;
    logic                 filt_req;
    logic                 done_r;
    logic [W_DELAY-1:0]   hs_cnt;
    logic [N_FLAGS-1:0]   flags;

    logic idle, busy, start_ok, dims_ok, abort;
    logic last_row, last_col, last_chn, last_ochn;
    logic beat, row_end, final_beat, to_filt;
    logic pf_clear, pf_active, pf_ready;
    logic pf_req;
    logic [W_SIZE-1:0] pf_row;

    assign idle     = state == ST_IDLE;
    assign busy     = !idle;
    assign start_ok = idle && bus.q_start && !bus.q_abort;
    assign dims_ok  = |bus.q_width && |bus.q_height
                   && |bus.q_in_chn && |bus.q_out_chn;
    assign abort    = busy && bus.q_abort;

    assign last_row  = row == cfg_h - ONE_S;
    assign last_col  = col == cfg_w - ONE_S;
    assign last_chn  = chn == cfg_ic - ONE_C;
    assign last_ochn = ochn == cfg_oc - ONE_C;

    assign beat       = (state == ST_DATA) && bus.q_pe_ready;
    assign row_end    = beat && last_col && last_chn;
    assign final_beat = row_end && last_row && last_ochn;
    assign to_filt    = row_end && last_row && !last_ochn;

    assign pf_clear  = abort || final_beat || to_filt;
    assign pf_active = (state == ST_HSYNC) || (state == ST_DATA);

    ifm_row_prefetch #(
        .W_SIZE   (W_SIZE),
        .IFM_ROWS (IFM_ROWS)
    ) u_prefetch (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (pf_clear),
        .active   (pf_active),
        .k3       (k3),
        .height   (cfg_h),
        .row      (row),
        .ifm_done (bus.q_ifm_done),
        .req_load (pf_req),
        .req_row  (pf_row),
        .ready    (pf_ready)
    );

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == ST_IDLE):
                if (start_ok && dims_ok) state_nxt = ST_FILT;
            (state == ST_FILT):
                if (abort) state_nxt = ST_IDLE;
                else if (bus.q_filter_done) state_nxt = ST_HSYNC;
            (state == ST_HSYNC):
                if (abort) state_nxt = ST_IDLE;
                else if (pf_ready) state_nxt = ST_DATA;
            (state == ST_DATA):
                if (abort || final_beat) state_nxt = ST_IDLE;
                else if (to_filt) state_nxt = ST_FILT;
                else if (row_end) state_nxt = ST_HSYNC;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            filt_req <= 1'b0;
            done_r   <= 1'b0;
            hs_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            filt_req <= (state_nxt == ST_FILT) && (state != ST_FILT);
            done_r   <= abort || (start_ok && !dims_ok);
            if (state_nxt == ST_HSYNC && state == ST_HSYNC)
                hs_cnt <= (&hs_cnt) ? hs_cnt : hs_cnt + ONE_D;
            else
                hs_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k3     <= 1'b0;
            cfg_w  <= '0;
            cfg_h  <= '0;
            cfg_ic <= '0;
            cfg_oc <= '0;
        end else if (start_ok) begin
            k3     <= bus.q_kernel3;
            cfg_w  <= bus.q_width;
            cfg_h  <= bus.q_height;
            cfg_ic <= bus.q_in_chn;
            cfg_oc <= bus.q_out_chn;
        end
    end

    // col fastest, then chn, then row, then ochn
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row  <= '0;
            col  <= '0;
            chn  <= '0;
            ochn <= '0;
        end else if (abort || final_beat) begin
            row  <= '0;
            col  <= '0;
            chn  <= '0;
            ochn <= '0;
        end else if (beat) begin
            if (!last_col) begin
                col <= col + ONE_S;
            end else begin
                col <= '0;
                if (!last_chn) begin
                    chn <= chn + ONE_C;
                end else begin
                    chn <= '0;
                    if (!last_row) begin
                        row <= row + ONE_S;
                    end else begin
                        row  <= '0;
                        ochn <= ochn + ONE_C;
                    end
                end
            end
        end
    end

    always_comb begin
        flags = '0;
        if (busy) begin
            flags[FLG_FIRST_ROW] = row == '0;
            flags[FLG_LAST_ROW]  = last_row;
            flags[FLG_FIRST_COL] = col == '0;
            flags[FLG_LAST_COL]  = last_col;
            flags[FLG_FIRST_CHN] = chn == '0;
            flags[FLG_LAST_CHN]  = last_chn;
        end
    end

    assign bus.o_filter_req   = filt_req;
    assign bus.o_ifm_req_load = pf_req;
    assign bus.o_ifm_req_row  = pf_row;
    assign bus.o_hsync_run    = state == ST_HSYNC;
    assign bus.o_data_run     = state == ST_DATA;
    assign bus.o_busy         = busy;
    assign bus.o_hsync_cnt    = hs_cnt;
    assign bus.o_row          = row;
    assign bus.o_col          = col;
    assign bus.o_chn          = chn;
    assign bus.o_ochn         = ochn;
    assign bus.o_flags        = flags;
    assign bus.o_beat         = beat;
    assign bus.o_done         = done_r || (final_beat && !abort);

endmodule
